// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous SRAM port between fetch (i_*) and load/store (d_*) requesters.
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic          i_wr,
    input  logic [3:0]    i_wstrb,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic          i_addr_ok,
    output logic          i_data_ok,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [3:0]    d_wstrb,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_addr_ok,
    output logic          d_data_ok,
    output logic [31:0]   d_rdata,
    output logic          m_en,
    output logic [3:0]    m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;
    state_t        state;
    logic [CW-1:0] starve;
    logic          starved, gnt_i, gnt_d;
    always_comb begin
        starved   = starve == CW'(STARVE_LIMIT);
        gnt_i     = !reset && i_req && (!d_req || starved);
        gnt_d     = !reset && d_req && !gnt_i;
        i_addr_ok = gnt_i;
        d_addr_ok = gnt_d;
        m_en      = gnt_i || gnt_d;
        m_addr    = gnt_i ? i_addr : d_addr;
        m_wdata   = gnt_i ? i_wdata : d_wdata;
        m_we      = gnt_i ? (i_wr ? i_wstrb : 4'b0) : gnt_d ? (d_wr ? d_wstrb : 4'b0) : 4'b0;
        // A response pending across a reset is dropped, not delivered.
        i_data_ok = !reset && state == RESP_I;
        d_data_ok = !reset && state == RESP_D;
        i_rdata   = m_rdata;
        d_rdata   = m_rdata;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state  <= gnt_i ? RESP_I : gnt_d ? RESP_D : IDLE;
            starve <= (!i_req || gnt_i) ? '0 : starved ? starve : starve + CW'(1);
        end
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks plus a per-cycle behavioural model of the arbiter.
module tb_sram_port_arbiter;
    localparam int AW = 32;
    localparam int SL = 4;
    logic          clk = 0, reset = 1;
    logic          i_req = 0, i_wr = 0, d_req = 0, d_wr = 0;
    logic [3:0]    i_wstrb = 0, d_wstrb = 0;
    logic [AW-1:0] i_addr = 0, d_addr = 0;
    logic [31:0]   i_wdata = 0, d_wdata = 0;
    logic          i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_en;
    logic [31:0]   i_rdata, d_rdata, m_wdata;
    logic [31:0]   m_rdata = 0;
    logic [3:0]    m_we;
    logic [AW-1:0] m_addr;
    int            checks = 0, failures = 0;
    logic [31:0]   mem [0:255];
    int            starve = 0, pend = 0;
    bit            pend_rd = 0;
    logic [31:0]   pend_data = 0;

    sram_port_arbiter #(.STARVE_LIMIT(SL), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_wr(i_wr), .i_wstrb(i_wstrb), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // 0 = nobody, 1 = instruction, 2 = data
    function automatic int winner();
        if (reset) return 0;
        if (i_req && (!d_req || starve >= SL)) return 1;
        return d_req ? 2 : 0;
    endfunction

    // Read-first synchronous SRAM with byte enables.
    always @(posedge clk)
        if (m_en) begin
            m_rdata <= mem[m_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (m_we[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
        end

    always @(posedge clk) begin
        int w;
        logic [AW-1:0] a;
        w = winner();
        a = (w == 1) ? i_addr : d_addr;
        starve    <= (reset || !i_req || w == 1) ? 0 : (starve < SL ? starve + 1 : starve);
        pend      <= w;
        pend_rd   <= (w == 1) ? !i_wr : !d_wr;
        pend_data <= mem[a[9:2]];
    end

    always @(negedge clk) begin
        int w;
        logic [3:0] we;
        w  = winner();
        we = (w == 1) ? (i_wr ? i_wstrb : 4'h0) : (w == 2) ? (d_wr ? d_wstrb : 4'h0) : 4'h0;
        chk("i_addr_ok", {31'b0, i_addr_ok}, {31'b0, w == 1});
        chk("d_addr_ok", {31'b0, d_addr_ok}, {31'b0, w == 2});
        chk("m_en", {31'b0, m_en}, {31'b0, w != 0});
        chk("m_we", {28'b0, m_we}, {28'b0, we});
        if (w != 0) begin
            chk("m_addr", m_addr, (w == 1) ? i_addr : d_addr);
            chk("m_wdata", m_wdata, (w == 1) ? i_wdata : d_wdata);
        end
        chk("i_data_ok", {31'b0, i_data_ok}, {31'b0, !reset && pend == 1});
        chk("d_data_ok", {31'b0, d_data_ok}, {31'b0, !reset && pend == 2});
        if (!reset && pend == 1 && pend_rd) chk("i_rdata", i_rdata, pend_data);
        if (!reset && pend == 2 && pend_rd) chk("d_rdata", d_rdata, pend_data);
    end

    initial begin
        logic [5:0]  igrant;
        logic [31:0] rd_exp [0:2];
        igrant = 6'b010000;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h0280_0C0C;
        rd_exp[0] = 32'h0280_0C0C;
        rd_exp[1] = 32'h1000_0001;
        rd_exp[2] = 32'h1000_0002;
        i_req = 1; d_req = 1;
        @(negedge clk);
        chk("lit_reset_iaok", {31'b0, i_addr_ok}, 0);
        chk("lit_reset_men", {31'b0, m_en}, 0);
        cyc(); cyc();
        reset = 0; d_req = 0; i_addr = 32'h1C00_0000;
        @(negedge clk);
        chk("lit_fetch_iaok", {31'b0, i_addr_ok}, 1);
        chk("lit_fetch_men", {31'b0, m_en}, 1);
        cyc();
        i_req = 0;
        @(negedge clk);
        chk("lit_fetch_dok", {31'b0, i_data_ok}, 1);
        chk("lit_fetch_rdata", i_rdata, 32'h0280_0C0C);
        cyc();
        i_req = 1; d_req = 1; d_wr = 1; d_wstrb = 4'hF; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lit_simul_daok", {31'b0, d_addr_ok}, 1);
        chk("lit_simul_iaok", {31'b0, i_addr_ok}, 0);
        chk("lit_simul_mwe", {28'b0, m_we}, 32'hF);
        chk("lit_simul_maddr", m_addr, 32'h100);
        cyc();
        i_req = 0; d_req = 0; d_wr = 0;
        @(negedge clk);
        chk("lit_simul_dok", {31'b0, d_data_ok}, 1);
        cyc();
        i_req = 1; d_req = 1; i_addr = 32'h40; d_addr = 32'h44;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("lit_starve_i%0d", k), {31'b0, i_addr_ok}, {31'b0, igrant[k]});
            chk($sformatf("lit_starve_d%0d", k), {31'b0, d_addr_ok}, {31'b0, !igrant[k]});
            cyc();
        end
        i_req = 0;
        for (int k = 0; k < 4; k++) begin
            d_req = k < 3;
            d_addr = 32'(4 * k);
            @(negedge clk);
            chk($sformatf("lit_b2b_men%0d", k), {31'b0, m_en}, {31'b0, k < 3});
            if (k > 0) begin
                chk($sformatf("lit_b2b_dok%0d", k), {31'b0, d_data_ok}, 1);
                chk($sformatf("lit_b2b_rdata%0d", k), d_rdata, rd_exp[k-1]);
            end
            cyc();
        end
        i_req = 1; i_addr = 32'h8;
        @(negedge clk);
        chk("lit_rstmid_iaok", {31'b0, i_addr_ok}, 1);
        cyc();
        reset = 1; i_req = 0;
        @(negedge clk);
        chk("lit_rstmid_dok1", {31'b0, i_data_ok}, 0);
        cyc();
        reset = 0;
        @(negedge clk);
        chk("lit_rstmid_dok2", {31'b0, i_data_ok}, 0);
        cyc();
        d_req = 1; d_wr = 1; d_wstrb = 4'h0; d_addr = 32'h10;
        @(negedge clk);
        chk("lit_strb0_men", {31'b0, m_en}, 1);
        chk("lit_strb0_mwe", {28'b0, m_we}, 0);
        cyc();
        d_req = 0; d_wr = 0;
        @(negedge clk);
        chk("lit_strb0_dok", {31'b0, d_data_ok}, 1);
        cyc();
        i_req = 1; i_wr = 1; i_wstrb = 4'b0011; i_addr = 32'h20; i_wdata = 32'hCAFE_1234;
        @(negedge clk);
        chk("lit_iwr_mwe", {28'b0, m_we}, 32'h3);
        cyc();
        i_wr = 0;
        cyc();
        i_req = 0;
        @(negedge clk);
        chk("lit_iwr_readback", i_rdata, 32'h1000_1234);
        cyc();
        for (int k = 0; k < 60; k++) begin
            i_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 2) != 0);
            i_wr = 1'($urandom_range(0, 1)); d_wr = 1'($urandom_range(0, 1));
            i_wstrb = 4'($urandom); d_wstrb = 4'($urandom);
            i_addr = 32'($urandom_range(0, 63) * 4); d_addr = 32'($urandom_range(0, 63) * 4);
            i_wdata = $urandom; d_wdata = $urandom;
            reset = ($urandom_range(0, 19) == 0);
            cyc();
        end
        reset = 0; i_req = 0; d_req = 0;
        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive denied cycles after which a pending instruction request wins.
REQ-002 SHALL have parameter AW, default 32: the address width.
REQ-003 SHALL have port clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 SHALL have instruction port inputs: i_req 1, i_wr 1, i_wstrb 4, i_addr AW, i_wdata 32.
REQ-006 SHALL have instruction port outputs: i_addr_ok 1 (request accepted), i_data_ok 1 (response valid), i_rdata 32.
REQ-007 SHALL have data port inputs: d_req 1, d_wr 1, d_wstrb 4, d_addr AW, d_wdata 32.
REQ-008 SHALL have data port outputs: d_addr_ok 1, d_data_ok 1, d_rdata 32.
REQ-009 SHALL have memory side outputs: m_en 1, m_we 4, m_addr AW, m_wdata 32.
REQ-010 SHALL have memory side input m_rdata 32, valid one cycle after m_en.

Function
REQ-011 SHALL share the single synchronous SRAM port between the fetch requester (i_*) and the load/store requester (d_*), granting at most one request per cycle.
REQ-012 SHALL compute the grant combinationally from the current-cycle req signals and the registered state.
- The winner's addr_ok SHALL be asserted in the same cycle.
- m_en=1 SHALL be driven in that same cycle, with m_addr and m_wdata muxed from the winner.
REQ-013 SHALL drive m_we = wstrb of the winner when its wr=1, and 4'b0 otherwise; m_we SHALL be 0 whenever m_en=0.
REQ-014 SHALL default to fixed priority data over instruction.
REQ-015 SHALL keep a starvation counter that increments, saturating at STARVE_LIMIT, in each cycle where i_req=1 and the instruction port is not granted.
- The counter SHALL clear when the instruction port is granted or when i_req=0.
REQ-016 SHALL grant the instruction port over the data port when the starvation counter equals STARVE_LIMIT.
REQ-017 SHALL maintain a response FSM with states IDLE, RESP_I and RESP_D, registered each cycle:
- next = RESP_I if the instruction port is granted;
- next = RESP_D if the data port is granted;
- next = IDLE otherwise.
REQ-018 SHALL assert exactly one data_ok per accepted request, in the cycle after acceptance:
- in RESP_I: i_data_ok=1 and i_rdata=m_rdata;
- in RESP_D: d_data_ok=1 and d_rdata=m_rdata;
- rdata is don't-care when data_ok=0.
REQ-019 SHALL assert data_ok for writes as well, with rdata don't-care.
REQ-020 SHALL permit back-to-back grants: a new grant may occur in the same cycle as the previous request's data_ok, giving a throughput of 1 request per cycle.
REQ-021 SHALL drive addr_ok=0 for a port whose req=0, and SHALL never assert both addr_ok signals in one cycle.
REQ-022 SHALL accept i_wr=1 from the instruction port and treat it identically to a data-port write.
REQ-023 SHALL leave address and data contents unchecked; alignment is the requester's responsibility.

Reset
REQ-024 SHALL, while reset=1, hold:
- FSM in IDLE and starvation counter at 0;
- all addr_ok, data_ok and m_en at 0, and m_we at 0.
REQ-025 SHALL, when reset is asserted in the cycle following a grant, drop the pending response: no data_ok is issued after reset.
REQ-026 SHALL ignore requests presented during reset; their addr_ok SHALL be 0.
REQ-027 SHALL accept a request in the first cycle after reset deasserts.

Verification
REQ-028 Single fetch:
- stimulus: i_req=1, i_addr=0x1C000000, m_rdata next cycle=0x02800C0C;
- response: i_addr_ok=1 and m_en=1 in cycle 0, i_data_ok=1 with i_rdata=0x02800C0C in cycle 1.
REQ-029 Simultaneous requests:
- stimulus: i_req=d_req=1, d_wr=1, d_wstrb=4'hF, d_addr=0x100, d_wdata=0xDEADBEEF;
- response: d_addr_ok=1, m_we=4'hF, m_addr=0x100 and i_addr_ok=0 in cycle 0;
- d_data_ok=1 in cycle 1.
REQ-030 Starvation, STARVE_LIMIT=4:
- stimulus: i_req and d_req held high 6 cycles;
- response: data granted in cycles 0-3, instruction granted in cycle 4 (counter=4), data granted in cycle 5.
REQ-031 Back-to-back:
- stimulus: d_req for 3 consecutive cycles, reads of 0x0, 0x4, 0x8;
- response: d_data_ok high in cycles 1-3 with matching rdata, m_en high in cycles 0-2.
REQ-032 Reset mid-operation:
- stimulus: i_req granted in cycle 0, reset=1 in cycle 1;
- response: i_data_ok=0 in cycles 1-2, FSM in IDLE, counter at 0.
REQ-033 Write strobe:
- stimulus: d_wr=1, d_wstrb=4'b0000;
- response: m_en=1, m_we=0, d_data_ok=1 next cycle.
